rv32i_encoder: RTL and testbench

- Inverse of the decode stage: takes instruction fields (format, funct3, register addresses, immediate) and emits packed 32-bit RV32I instruction words.
- Words are tagged with a sequential word address, ready to be written into instruction memory.
- Used by the self-test loader and debug injector to build programs in hardware.
- Input and output use valid/ready handshakes, with one registered output stage, range/legality checking and a sticky error flag.

---
 rtl/rv32i_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_rv32i_encoder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_encoder.sv
// rv32i_encoder: packs RV32I instruction fields into 32-bit words and
// streams them out through one registered stage with a word address.
module rv32i_encoder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_fmt,
    input  logic [2:0]            i_funct3,
    input  logic                  i_alt,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_rs1,
    input  logic [4:0]            i_rs2,
    input  logic [31:0]           i_imm,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_inst,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_err,
    output logic                  o_err_sticky,
    input  logic                  i_err_clr,
    input  logic                  i_addr_load,
    input  logic [ADDR_WIDTH-1:0] i_addr_base
);

    localparam logic [3:0] FMT_R      = 4'd0;
    localparam logic [3:0] FMT_I      = 4'd1;
    localparam logic [3:0] FMT_LOAD   = 4'd2;
    localparam logic [3:0] FMT_STORE  = 4'd3;
    localparam logic [3:0] FMT_BRANCH = 4'd4;
    localparam logic [3:0] FMT_JAL    = 4'd5;
    localparam logic [3:0] FMT_JALR   = 4'd6;
    localparam logic [3:0] FMT_LUI    = 4'd7;
    localparam logic [3:0] FMT_AUIPC  = 4'd8;
    localparam logic [3:0] FMT_SYSTEM = 4'd9;
    localparam logic [3:0] FMT_FENCE  = 4'd10;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_FENCE  = 7'h0F;

    logic                  valid_q, valid_d;
    logic [31:0]           inst_q, inst_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  sticky_q, sticky_d;

    logic        accept;
    logic        xfer;
    logic        sext12_ok;
    logic        sext13_ok;
    logic        sext21_ok;
    logic        is_shift;
    logic        alt_ok;
    logic        fmt_bad;
    logic        imm_bad;
    logic        f3_bad;
    logic        enc_err;
    logic [31:0] word;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign xfer    = valid_q && i_ready;

    // Upper bits must all replicate the top bit of the encodable field.
    assign sext12_ok = (&i_imm[31:11]) | (~|i_imm[31:11]);
    assign sext13_ok = (&i_imm[31:12]) | (~|i_imm[31:12]);
    assign sext21_ok = (&i_imm[31:20]) | (~|i_imm[31:20]);

    assign is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        word    = '0;
        alt_ok  = 1'b0;
        fmt_bad = 1'b0;
        imm_bad = 1'b0;
        f3_bad  = 1'b0;
        unique case (i_fmt)
            FMT_R: begin
                alt_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b101);
                word   = {1'b0, i_alt, 5'b0, i_rs2, i_rs1,
                          i_funct3, i_rd, OP_R};
            end
            FMT_I: begin
                if (is_shift) begin
                    alt_ok  = (i_funct3 == 3'b101);
                    imm_bad = |i_imm[31:5];
                    word    = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1,
                               i_funct3, i_rd, OP_I};
                end else begin
                    imm_bad = !sext12_ok;
                    word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                end
            end
            FMT_LOAD: begin
                imm_bad = !sext12_ok;
                f3_bad  = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                          (i_funct3 == 3'b111);
                word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            end
            FMT_STORE: begin
                imm_bad = !sext12_ok;
                f3_bad  = (i_funct3 >= 3'b011);
                word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:0], OP_STORE};
            end
            FMT_BRANCH: begin
                imm_bad = !sext13_ok || i_imm[0];
                f3_bad  = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
                word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], OP_BRANCH};
            end
            FMT_JAL: begin
                imm_bad = !sext21_ok || i_imm[0];
                word    = {i_imm[20], i_imm[10:1], i_imm[11],
                           i_imm[19:12], i_rd, OP_JAL};
            end
            FMT_JALR: begin
                imm_bad = !sext12_ok;
                f3_bad  = (i_funct3 != 3'b000);
                word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
            end
            FMT_LUI: begin
                imm_bad = |i_imm[11:0];
                word    = {i_imm[31:12], i_rd, OP_LUI};
            end
            FMT_AUIPC: begin
                imm_bad = |i_imm[11:0];
                word    = {i_imm[31:12], i_rd, OP_AUIPC};
            end
            FMT_SYSTEM: begin
                imm_bad = |i_imm[31:12];
                word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_SYSTEM};
            end
            FMT_FENCE: begin
                imm_bad = |i_imm[31:12];
                word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_FENCE};
            end
            default: begin
                fmt_bad = 1'b1;
            end
        endcase
    end

    assign enc_err = fmt_bad || imm_bad || f3_bad || (i_alt && !alt_ok);

    always_comb begin
        valid_d  = valid_q;
        inst_d   = inst_q;
        err_d    = err_q;
        addr_d   = addr_q;
        sticky_d = sticky_q;
        if (accept) begin
            valid_d = 1'b1;
            inst_d  = enc_err ? 32'h0 : word;
            err_d   = enc_err;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        // A base load overrides the post-transfer increment.
        if (i_addr_load) begin
            addr_d = i_addr_base;
        end else if (xfer) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (xfer && err_q) begin
            sticky_d = 1'b1;
        end else if (i_err_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            inst_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_inst       = inst_q;
    assign o_err        = err_q;
    assign o_addr       = addr_q;
    assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// tb_rv32i_encoder: directed and randomized checks of rv32i_encoder
// against an arithmetic reference encoder and a handshake model.
module tb_rv32i_encoder;

    localparam int AW = 4;
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23,
        7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [3:0]    i_fmt;
    logic [2:0]    i_funct3;
    logic          i_alt;
    logic [4:0]    i_rd;
    logic [4:0]    i_rs1;
    logic [4:0]    i_rs2;
    logic [31:0]   i_imm;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_inst;
    logic [AW-1:0] o_addr;
    logic          o_err;
    logic          o_err_sticky;
    logic          i_err_clr;
    logic          i_addr_load;
    logic [AW-1:0] i_addr_base;

    int n_checks = 0;
    int n_errors = 0;
    int n_sent   = 0;
    int n_done   = 0;
    int n_drop   = 0;

    bit            mon_en     = 0;
    bit            rand_ready = 0;
    bit            ready_fix  = 1;
    logic [31:0]   drv_inst   = '0;
    bit            drv_err    = 0;
    bit            vm         = 0;
    logic [31:0]   cur_inst   = '0;
    bit            cur_err    = 0;
    logic [AW-1:0] am         = '0;
    bit            sm         = 0;
    bit            m_rdy;
    bit            m_acc;
    bit            m_xfer;

    rv32i_encoder #(.ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_fmt(i_fmt), .i_funct3(i_funct3), .i_alt(i_alt),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_inst(o_inst), .o_addr(o_addr), .o_err(o_err),
        .o_err_sticky(o_err_sticky), .i_err_clr(i_err_clr),
        .i_addr_load(i_addr_load), .i_addr_base(i_addr_base)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Returns {err, word}; built from the field layout with shifts.
    function automatic logic [32:0] enc_ref(input int fmt, input int f3,
        input bit alt, input int rd, input int rs1, input int rs2,
        input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] ib;
        logic [31:0] sb;
        bit bad;
        bit alt_ok;
        int s;
        if (fmt > 10) return {1'b1, 32'h0};
        s = $signed(imm);
        w = {25'b0, OPS[fmt]};
        ib = (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        sb = (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
        bad = 0;
        alt_ok = 0;
        case (fmt)
            0: begin
                alt_ok = (f3 == 0) || (f3 == 5);
                w |= ib | (32'(rs2) << 20) | (32'(alt) << 30);
            end
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    alt_ok = (f3 == 5);
                    bad = imm > 31;
                    w |= ib | ((imm & 31) << 20) | (32'(alt) << 30);
                end else begin
                    bad = s < -2048 || s > 2047;
                    w |= ib | ((imm & 32'hfff) << 20);
                end
            end
            2, 6: begin
                bad = s < -2048 || s > 2047;
                if (fmt == 2) bad |= (f3 == 3 || f3 == 6 || f3 == 7);
                else bad |= (f3 != 0);
                w |= ib | ((imm & 32'hfff) << 20);
            end
            3: begin
                bad = s < -2048 || s > 2047 || f3 >= 3;
                w |= sb | ((imm & 31) << 7) | (((imm >> 5) & 127) << 25);
            end
            4: begin
                bad = s < -4096 || s > 4095 || imm[0] || f3 == 2 || f3 == 3;
                w |= sb | (((imm >> 12) & 1) << 31)
                   | (((imm >> 5) & 63) << 25)
                   | (((imm >> 1) & 15) << 8)
                   | (((imm >> 11) & 1) << 7);
            end
            5: begin
                bad = s < -(1 << 20) || s >= (1 << 20) || imm[0];
                w |= (32'(rd) << 7) | (((imm >> 20) & 1) << 31)
                   | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 255) << 12);
            end
            7, 8: begin
                bad = (imm & 32'hfff) != 0;
                w |= (32'(rd) << 7) | (imm & 32'hfffff000);
            end
            default: begin
                bad = imm > 32'hfff;
                w |= ib | ((imm & 32'hfff) << 20);
            end
        endcase
        bad = bad || (alt && !alt_ok);
        return bad ? {1'b1, 32'h0} : {1'b0, w};
    endfunction

    task automatic send(input int fmt, input int f3, input bit alt,
        input int rd, input int rs1, input int rs2,
        input logic [31:0] imm, input logic [31:0] ei, input bit ee);
        bit acc;
        int n;
        i_fmt    = 4'(fmt);
        i_funct3 = 3'(f3);
        i_alt    = alt;
        i_rd     = 5'(rd);
        i_rs1    = 5'(rs1);
        i_rs2    = 5'(rs2);
        i_imm    = imm;
        drv_inst = ei;
        drv_err  = ee;
        i_valid  = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            n++;
        end
        check("send_accept", 32'(acc), 32'd1);
        if (acc) n_sent++;
        i_valid = 1'b0;
    endtask

    task automatic send_ref(input int fmt, input int f3, input bit alt,
        input int rd, input int rs1, input int rs2,
        input logic [31:0] imm);
        logic [32:0] r;
        r = enc_ref(fmt, f3, alt, rd, rs1, rs2, imm);
        send(fmt, f3, alt, rd, rs1, rs2, imm, r[31:0], r[32]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("drain", 32'(o_valid), 32'd0);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #2;
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Handshake/address/sticky model, sampled mid-cycle.
    initial forever begin
        @(negedge i_clk);
        if (mon_en) begin
            m_rdy = !vm || i_ready;
            check("o_valid", 32'(o_valid), 32'(vm));
            check("o_ready", 32'(o_ready), 32'(m_rdy));
            check("o_addr", 32'(o_addr), 32'(am));
            check("o_err_sticky", 32'(o_err_sticky), 32'(sm));
            if (vm) begin
                check("o_inst", o_inst, cur_inst);
                check("o_err", 32'(o_err), 32'(cur_err));
            end
            if (i_rst) begin
                if (vm) n_drop++;
                vm = 0;
                am = '0;
                sm = 0;
            end else begin
                m_xfer = vm && i_ready;
                m_acc  = i_valid && m_rdy;
                if (m_xfer) n_done++;
                if (m_xfer && cur_err) sm = 1;
                else if (i_err_clr) sm = 0;
                if (i_addr_load) am = i_addr_base;
                else if (m_xfer) am = am + 1'b1;
                if (m_acc) begin
                    vm = 1;
                    cur_inst = drv_inst;
                    cur_err = drv_err;
                end else if (m_xfer) begin
                    vm = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        int fmt;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_fmt = '0;
        i_funct3 = '0;
        i_alt = 1'b0;
        i_rd = '0;
        i_rs1 = '0;
        i_rs2 = '0;
        i_imm = '0;
        i_err_clr = 1'b0;
        i_addr_load = 1'b0;
        i_addr_base = '0;
        tick(3);
        i_rst = 1'b0;
        mon_en = 1;
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_sticky", 32'(o_err_sticky), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        tick(1);

        send(0, 0, 0, 1, 2, 3, 0, 32'h003100B3, 0);
        send(0, 0, 1, 1, 2, 3, 0, 32'h403100B3, 0);
        send(1, 0, 0, 5, 0, 0, 32'hFFFFFFFF, 32'hFFF00293, 0);
        send(5, 0, 0, 1, 0, 0, 32'h800, 32'h001000EF, 0);
        send(7, 0, 0, 2, 0, 0, 32'h12345000, 32'h12345137, 0);
        send(4, 0, 0, 0, 1, 2, 3, 32'h0, 1);
        send(1, 1, 0, 3, 4, 0, 32, 32'h0, 1);
        drain();
        check("sticky_set", 32'(o_err_sticky), 32'd1);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        @(negedge i_clk);
        check("sticky_clr", 32'(o_err_sticky), 32'd0);
        tick(1);

        i_addr_load = 1'b1;
        i_addr_base = '0;
        tick(1);
        i_addr_load = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(0, 0, 0, k + 4, k, k + 1, 0,
                         32'h33 | (32'(k + 4) << 7) | (32'(k) << 15)
                         | (32'(k + 1) << 20), 0);
            end
            begin
                tick(1);
                ready_fix = 0;
                tick(3);
                ready_fix = 1;
            end
        join
        drain();
        check("bp_addr_end", 32'(o_addr), 32'd4);

        i_addr_load = 1'b1;
        i_addr_base = 4'd14;
        tick(1);
        i_addr_load = 1'b0;
        for (int k = 0; k < 3; k++) send_ref(7, 0, 0, k, 0, 0, 32'(k) << 12);
        drain();
        check("wrap_addr", 32'(o_addr), 32'd1);
        send_ref(8, 0, 0, 9, 0, 0, 32'hABCDE000);
        i_addr_load = 1'b1;
        i_addr_base = 4'd5;
        tick(1);
        i_addr_load = 1'b0;
        @(negedge i_clk);
        check("load_wins", 32'(o_addr), 32'd5);
        tick(1);

        rand_ready = 1;
        for (int k = 0; k < 300; k++) begin
            fmt = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15)
                                              : $urandom_range(0, 10);
            r = $urandom;
            case ($urandom_range(0, 4))
                0: imm = r;
                1: imm = {{20{r[11]}}, r[11:0]};
                2: imm = {{19{r[12]}}, r[12:1], 1'b0};
                3: imm = {{11{r[20]}}, r[20:1], 1'b0};
                default: imm = ($urandom_range(0, 1) == 1)
                    ? {r[31:12], 12'h0} : {27'h0, r[4:0]};
            endcase
            i_err_clr = ($urandom_range(0, 7) == 0);
            i_addr_load = ($urandom_range(0, 31) == 0);
            i_addr_base = 4'($urandom);
            send_ref(fmt, $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), imm);
            if ($urandom_range(0, 5) == 0) tick(1);
        end
        i_err_clr = 1'b0;
        i_addr_load = 1'b0;
        rand_ready = 0;
        ready_fix = 1;
        tick(1);
        drain();

        send(4, 0, 0, 0, 1, 2, 3, 32'h0, 1);
        drain();
        tick(1);
        check("pre_rst_sticky", 32'(o_err_sticky), 32'd1);
        ready_fix = 0;
        tick(1);
        send_ref(0, 0, 0, 7, 8, 9, 0);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_addr", 32'(o_addr), 32'd0);
        check("mid_rst_sticky", 32'(o_err_sticky), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        ready_fix = 1;
        tick(2);
        check("word_count", 32'(n_done + n_drop), 32'(n_sent));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
